// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int CTRL_STATE_W = 2;

   typedef enum logic [CTRL_STATE_W-1:0] {
      CTRL_IDLE     = 2'd0,
      CTRL_MEM_REQ  = 2'd1,
      CTRL_MEM_WAIT = 2'd2,
      CTRL_DIV_BUSY = 2'd3
   } ctrl_state_t;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read
// by the instruction in ID. Shared with the forwarding unit.
module pipe_ctrl_hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_rmem,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_rs1_ren,
   input  logic                  id_rs2_ren,
   output logic                  load_use
);

   // x0 is never a real dependency, so it never stalls.
   assign load_use = ex_rmem && (ex_rd_addr != '0) &&
                     ((id_rs1_ren && (id_rs1_addr == ex_rd_addr)) ||
                      (id_rs2_ren && (id_rs2_addr == ex_rd_addr)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage core. Sequences the data-bus
// request of the MEM instruction, holds the front end for the iterative
// divider, and resolves load-use hazards and EX jumps.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// CTRL_IDLE     | no multi-cycle event; a new bus request may issue here
// CTRL_MEM_REQ  | bus request raised, waiting for dbus_gnt
// CTRL_MEM_WAIT | load granted, waiting for dbus_rvalid
// CTRL_DIV_BUSY | divider running, front end held, bubbles into MEM
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    EX_jump,
   input  logic [31:0]             EX_jump_addr,
   input  logic                    EX_rmem,
   input  logic [REG_ADDR_W-1:0]   EX_rd_addr,
   input  logic [REG_ADDR_W-1:0]   ID_rs1_addr,
   input  logic [REG_ADDR_W-1:0]   ID_rs2_addr,
   input  logic                    ID_rs1_ren,
   input  logic                    ID_rs2_ren,
   input  logic                    EX_div_start,
   input  logic                    div_done,
   input  logic                    MEM_rmem,
   input  logic                    MEM_wmem,
   input  logic                    dbus_gnt,
   input  logic                    dbus_rvalid,
   output logic                    dbus_req,
   output logic                    jump_o,
   output logic [31:0]             jump_addr_o,
   output logic                    pc_hold,
   output logic                    IF_ID_hold,
   output logic                    ID_EX_hold,
   output logic                    EX_MEM_hold,
   output logic                    IF_ID_flush,
   output logic                    ID_EX_flush,
   output logic                    EX_MEM_flush,
   output logic                    MEM_WB_flush,
   output logic [CTRL_STATE_W-1:0] ctrl_state,
   output logic [CNT_W-1:0]        stall_cnt,
   output logic [CNT_W-1:0]        flush_cnt
);

   ctrl_state_t state, state_nxt;
   logic        mem_op;
   logic        mem_stall;
   logic        div_stall;
   logic        load_use;

   assign mem_op     = MEM_rmem | MEM_wmem;
   assign ctrl_state = state;

   pipe_ctrl_hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .ex_rmem     (EX_rmem),
      .ex_rd_addr  (EX_rd_addr),
      .id_rs1_addr (ID_rs1_addr),
      .id_rs2_addr (ID_rs2_addr),
      .id_rs1_ren  (ID_rs1_ren),
      .id_rs2_ren  (ID_rs2_ren),
      .load_use    (load_use)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= CTRL_IDLE;
      else       state <= state_nxt;
   end

   // Next state and all hold/flush/request outputs. Everything is gated by
   // rstn so the outputs drop the instant reset asserts, not at the next edge.
   always_comb begin
      state_nxt    = state;
      mem_stall    = 1'b0;
      div_stall    = 1'b0;
      dbus_req     = 1'b0;
      jump_o       = 1'b0;
      jump_addr_o  = ZERO_WORD;
      pc_hold      = 1'b0;
      IF_ID_hold   = 1'b0;
      ID_EX_hold   = 1'b0;
      EX_MEM_hold  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_flush = 1'b0;
      MEM_WB_flush = 1'b0;
      if (rstn) begin
         // A MEM instruction with MEM_rmem clear is treated as a store; it is
         // frozen in MEM while pending, so the type stays valid across states.
         unique case (state)
            CTRL_IDLE: begin
               if (mem_op) begin
                  dbus_req = 1'b1;
                  if (!(dbus_gnt && !MEM_rmem)) begin
                     mem_stall = 1'b1;
                     state_nxt = dbus_gnt ? CTRL_MEM_WAIT : CTRL_MEM_REQ;
                  end
               end else if (EX_div_start) begin
                  state_nxt = CTRL_DIV_BUSY;
               end
            end
            CTRL_MEM_REQ: begin
               dbus_req  = 1'b1;
               mem_stall = !(dbus_gnt && !MEM_rmem);
               if (dbus_gnt) state_nxt = MEM_rmem ? CTRL_MEM_WAIT : CTRL_IDLE;
            end
            CTRL_MEM_WAIT: begin
               if (dbus_rvalid) state_nxt = CTRL_IDLE;
               else             mem_stall = 1'b1;
            end
            CTRL_DIV_BUSY: begin
               if (div_done) state_nxt = CTRL_IDLE;
               else          div_stall = 1'b1;
            end
            default: state_nxt = CTRL_IDLE;
         endcase

         if (mem_stall) begin
            pc_hold      = 1'b1;
            IF_ID_hold   = 1'b1;
            ID_EX_hold   = 1'b1;
            EX_MEM_hold  = 1'b1;
            MEM_WB_flush = 1'b1;
         end else if (div_stall) begin
            pc_hold      = 1'b1;
            IF_ID_hold   = 1'b1;
            ID_EX_hold   = 1'b1;
            EX_MEM_flush = 1'b1;
         end else if (state != CTRL_DIV_BUSY) begin
            // Also taken on a memory completion cycle: the pipeline advances
            // then, so a jump or hazard in EX must not be lost.
            if (EX_jump) begin
               jump_o      = 1'b1;
               jump_addr_o = EX_jump_addr;
               IF_ID_flush = 1'b1;
               ID_EX_flush = 1'b1;
            end else if (load_use) begin
               pc_hold     = 1'b1;
               IF_ID_hold  = 1'b1;
               ID_EX_flush = 1'b1;
            end
         end
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Saturating counts of front-end stall cycles and front-end flush cycles.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_hold && (stall_cnt != '1))     stall_cnt <= stall_cnt + CNT_W'(1);
         if (IF_ID_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard, jump, bus handshake, divider and
// reset sequences with hand-computed expected control vectors.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        EX_jump;
   logic [31:0] EX_jump_addr;
   logic        EX_rmem;
   logic [4:0]  EX_rd_addr;
   logic [4:0]  ID_rs1_addr, ID_rs2_addr;
   logic        ID_rs1_ren, ID_rs2_ren;
   logic        EX_div_start, div_done;
   logic        MEM_rmem, MEM_wmem;
   logic        dbus_gnt, dbus_rvalid;
   logic        dbus_req, jump_o;
   logic [31:0] jump_addr_o;
   logic        pc_hold, IF_ID_hold, ID_EX_hold, EX_MEM_hold;
   logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
   logic [1:0]  ctrl_state;
   logic [31:0] stall_cnt, flush_cnt;
   logic [9:0]  ctl;

   int n_chk = 0;
   int n_bad = 0;

   // ctl bits: pc_hold IF_ID_hold ID_EX_hold EX_MEM_hold IF_ID_flush
   //           ID_EX_flush EX_MEM_flush MEM_WB_flush dbus_req jump_o
   localparam logic [9:0] C_NONE  = 10'b0000000000;
   localparam logic [9:0] C_LU    = 10'b1100010000;
   localparam logic [9:0] C_JMP   = 10'b0000110001;
   localparam logic [9:0] C_MREQ  = 10'b1111000110;
   localparam logic [9:0] C_MWAIT = 10'b1111000100;
   localparam logic [9:0] C_REQ   = 10'b0000000010;
   localparam logic [9:0] C_DIV   = 10'b1110001000;

   assign ctl = {pc_hold, IF_ID_hold, ID_EX_hold, EX_MEM_hold, IF_ID_flush,
                 ID_EX_flush, EX_MEM_flush, MEM_WB_flush, dbus_req, jump_o};

   pipe_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .EX_jump      (EX_jump),
      .EX_jump_addr (EX_jump_addr),
      .EX_rmem      (EX_rmem),
      .EX_rd_addr   (EX_rd_addr),
      .ID_rs1_addr  (ID_rs1_addr),
      .ID_rs2_addr  (ID_rs2_addr),
      .ID_rs1_ren   (ID_rs1_ren),
      .ID_rs2_ren   (ID_rs2_ren),
      .EX_div_start (EX_div_start),
      .div_done     (div_done),
      .MEM_rmem     (MEM_rmem),
      .MEM_wmem     (MEM_wmem),
      .dbus_gnt     (dbus_gnt),
      .dbus_rvalid  (dbus_rvalid),
      .dbus_req     (dbus_req),
      .jump_o       (jump_o),
      .jump_addr_o  (jump_addr_o),
      .pc_hold      (pc_hold),
      .IF_ID_hold   (IF_ID_hold),
      .ID_EX_hold   (ID_EX_hold),
      .EX_MEM_hold  (EX_MEM_hold),
      .IF_ID_flush  (IF_ID_flush),
      .ID_EX_flush  (ID_EX_flush),
      .EX_MEM_flush (EX_MEM_flush),
      .MEM_WB_flush (MEM_WB_flush),
      .ctrl_state   (ctrl_state),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      EX_jump      = 1'b0;
      EX_jump_addr = 32'h0;
      EX_rmem      = 1'b0;
      EX_rd_addr   = 5'd0;
      ID_rs1_addr  = 5'd0;
      ID_rs2_addr  = 5'd0;
      ID_rs1_ren   = 1'b0;
      ID_rs2_ren   = 1'b0;
      EX_div_start = 1'b0;
      div_done     = 1'b0;
      MEM_rmem     = 1'b0;
      MEM_wmem     = 1'b0;
      dbus_gnt     = 1'b0;
      dbus_rvalid  = 1'b0;
   endtask

   // Inputs are already applied (just after a rising edge); sample on the
   // falling edge, then step to just after the next rising edge.
   task automatic cyc(input string tag, input logic [9:0] exp_ctl, input logic [1:0] exp_st);
      @(negedge clk);
      chk(tag, 32'(ctl), 32'(exp_ctl));
      chk({tag, "/st"}, 32'(ctrl_state), 32'(exp_st));
      chk({tag, "/ovl"}, 32'((IF_ID_hold & IF_ID_flush) | (ID_EX_hold & ID_EX_flush)), 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      rstn = 1'b0;
      // Live requests during reset must not leak through to the outputs.
      MEM_rmem = 1'b1; EX_jump = 1'b1; EX_jump_addr = 32'h100;
      #3;
      chk("rst_ctl", 32'(ctl), 32'h0);
      chk("rst_st", 32'(ctrl_state), 32'h0);
      chk("rst_jaddr", jump_addr_o, 32'h0);
      chk("rst_scnt", stall_cnt, 32'h0);
      chk("rst_fcnt", flush_cnt, 32'h0);
      clr();
      @(posedge clk); #1;
      rstn = 1'b1;

      // load-use
      EX_rmem = 1'b1; EX_rd_addr = 5'd5; ID_rs1_addr = 5'd5; ID_rs1_ren = 1'b1;
      cyc("lu_rs1", C_LU, 2'd0);
      clr();
      cyc("lu_after", C_NONE, 2'd0);
      EX_rmem = 1'b1; EX_rd_addr = 5'd0; ID_rs1_addr = 5'd0; ID_rs1_ren = 1'b1;
      cyc("lu_x0", C_NONE, 2'd0);
      EX_rmem = 1'b1; EX_rd_addr = 5'd9; ID_rs1_addr = 5'd3; ID_rs2_addr = 5'd9; ID_rs2_ren = 1'b1;
      cyc("lu_rs2", C_LU, 2'd0);
      ID_rs2_ren = 1'b0;
      cyc("lu_noren", C_NONE, 2'd0);
      clr();
      EX_rd_addr = 5'd9; ID_rs1_addr = 5'd9; ID_rs1_ren = 1'b1;
      cyc("lu_noload", C_NONE, 2'd0);

      // jump, then jump overriding load-use
      clr();
      EX_jump = 1'b1; EX_jump_addr = 32'h0000_0100;
      #2;
      chk("jmp_addr", jump_addr_o, 32'h0000_0100);
      cyc("jmp", C_JMP, 2'd0);
      EX_rmem = 1'b1; EX_rd_addr = 5'd5; ID_rs1_addr = 5'd5; ID_rs1_ren = 1'b1;
      cyc("jmp_lu", C_JMP, 2'd0);
      clr();
      cyc("jmp_after", C_NONE, 2'd0);

      // store, grant after 3 cycles; a jump during the stall is suppressed
      MEM_wmem = 1'b1;
      cyc("st_w0", C_MREQ, 2'd0);
      EX_jump = 1'b1; EX_jump_addr = 32'h200;
      cyc("st_w1", C_MREQ, 2'd1);
      EX_jump = 1'b0;
      cyc("st_w2", C_MREQ, 2'd1);
      dbus_gnt = 1'b1;
      cyc("st_gnt", C_REQ, 2'd1);
      clr();
      cyc("st_idle", C_NONE, 2'd0);

      // store, zero-delay grant
      MEM_wmem = 1'b1; dbus_gnt = 1'b1;
      cyc("st0", C_REQ, 2'd0);
      clr();
      cyc("st0_idle", C_NONE, 2'd0);

      // load, grant at once, rvalid two cycles later
      MEM_rmem = 1'b1; dbus_gnt = 1'b1;
      cyc("ld_gnt", C_MREQ, 2'd0);
      dbus_gnt = 1'b0;
      cyc("ld_wait", C_MWAIT, 2'd2);
      dbus_rvalid = 1'b1;
      cyc("ld_rv", C_NONE, 2'd2);
      clr();
      cyc("ld_idle", C_NONE, 2'd0);

      // load in MEM together with a divide in EX: memory first, then divider
      MEM_rmem = 1'b1; EX_div_start = 1'b1;
      cyc("dl_req0", C_MREQ, 2'd0);
      dbus_gnt = 1'b1;
      cyc("dl_gnt", C_MREQ, 2'd1);
      dbus_gnt = 1'b0; dbus_rvalid = 1'b1;
      cyc("dl_rv", C_NONE, 2'd2);
      clr();
      EX_div_start = 1'b1;
      cyc("dl_dstart", C_NONE, 2'd0);
      clr();
      cyc("dl_div0", C_DIV, 2'd3);
      MEM_wmem = 1'b1;
      cyc("dl_div1", C_DIV, 2'd3);
      MEM_wmem = 1'b0;
      cyc("dl_div2", C_DIV, 2'd3);
      div_done = 1'b1;
      cyc("dl_done", C_NONE, 2'd3);
      clr();
      cyc("dl_idle", C_NONE, 2'd0);

`ifdef PIPE_PERF_CNT_EN
      // pc_hold cycles: 2 load-use + 3 store + 2 load + 2 mem + 3 div = 12
      chk("scnt", stall_cnt, 32'd12);
      chk("fcnt", flush_cnt, 32'd2);
`else
      chk("scnt", stall_cnt, 32'd0);
      chk("fcnt", flush_cnt, 32'd0);
`endif

      // asynchronous reset while waiting for load data
      MEM_rmem = 1'b1; dbus_gnt = 1'b1;
      cyc("rs_gnt", C_MREQ, 2'd0);
      dbus_gnt = 1'b0;
      @(negedge clk);
      chk("rs_wait_st", 32'(ctrl_state), 32'd2);
      chk("rs_wait_ctl", 32'(ctl), 32'(C_MWAIT));
      #1;
      rstn = 1'b0;
      #1;
      chk("rs_st", 32'(ctrl_state), 32'd0);
      chk("rs_ctl", 32'(ctl), 32'h0);
      chk("rs_scnt", stall_cnt, 32'h0);
      @(posedge clk); #1;
      clr();
      rstn = 1'b1;
      cyc("rs_after", C_NONE, 2'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V core. It drives hold and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three cases: load-use hazards, taken jumps from EX, and multi-cycle events (data-bus handshake in MEM, iterative divider in EX). It contains the FSM that sequences the data-bus request for the instruction in MEM.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 32, performance counter width (used only with the optional feature)

Ports:
clk  in  1  core clock
rstn  in  1  reset, asynchronous, active-low
EX_jump  in  1  taken jump/branch resolved in EX
EX_jump_addr  in  32  jump target
EX_rmem  in  1  EX instruction is a load
EX_rd_addr  in  REG_ADDR_W  EX destination register
ID_rs1_addr, ID_rs2_addr  in  REG_ADDR_W each  ID source registers
ID_rs1_ren, ID_rs2_ren  in  1 each  source-register read enables
EX_div_start  in  1  divide instruction entering the divider
div_done  in  1  divider result valid (1-cycle pulse)
MEM_rmem, MEM_wmem  in  1 each  MEM-stage load / store
dbus_gnt  in  1  bus accepted request
dbus_rvalid  in  1  load data valid
dbus_req  out  1  bus request
jump_o  out  1  redirect PC
jump_addr_o  out  32  redirect target
pc_hold, IF_ID_hold, ID_EX_hold, EX_MEM_hold  out  1 each  keep current value
IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load bubble (default value)
ctrl_state  out  2  FSM state, for debug
stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset: FSM enters IDLE. All hold/flush/dbus_req/jump_o outputs are 0, jump_addr_o is 0, and the counters are 0. Every output is combinational from the state and the inputs, except the counters.
- States: IDLE=0, MEM_REQ=1, MEM_WAIT=2, DIV_BUSY=3.
- mem_op = MEM_rmem | MEM_wmem. dbus_req = (IDLE & mem_op) | MEM_REQ.
- IDLE with mem_op:
  - Write with dbus_gnt: done, no stall.
  - Read with dbus_gnt: go to MEM_WAIT.
  - No gnt: go to MEM_REQ.
- MEM_REQ: on gnt, a write goes to IDLE and a read goes to MEM_WAIT.
- MEM_WAIT: on dbus_rvalid, go to IDLE.
- mem_stall = a memory access is pending and not completing this cycle. While mem_stall holds:
  - pc_hold, IF_ID_hold, ID_EX_hold and EX_MEM_hold are asserted.
  - MEM_WB_flush is asserted.
  - Jump, load-use and divide actions are suppressed. The EX instruction is frozen and re-evaluated after release.
- The completion cycle (gnt for a write, rvalid for a read) is not stalled, so the pipeline advances that same cycle.
- DIV_BUSY:
  - Entered from IDLE on EX_div_start when there is no mem_op.
  - pc_hold, IF_ID_hold and ID_EX_hold are asserted; EX_MEM_flush inserts a bubble.
  - On div_done: release that cycle and go to IDLE.
- Memory accesses have priority over the divider. If EX_div_start and mem_op occur together, memory is served first and the divide starts after return to IDLE.
- A divide cannot reach MEM while in DIV_BUSY. Any mem_op seen in DIV_BUSY is ignored until return to IDLE.
- Jump (IDLE, not mem_stall):
  - jump_o = EX_jump and jump_addr_o = EX_jump_addr.
  - IF_ID_flush and ID_EX_flush are asserted for that cycle. Single-cycle, no state change.
- Load-use:
  - Condition: EX_rmem & EX_rd_addr≠0 & ((ID_rs1_ren & rs1==rd) | (ID_rs2_ren & rs2==rd)).
  - Action: pc_hold, IF_ID_hold and ID_EX_flush for 1 cycle.
  - A jump in the same cycle overrides load-use: flush, no hold.
- flush dominates hold on the same register. The two are never asserted together by this block; the verifier asserts this.
- Asynchronous reset mid-transaction: FSM returns to IDLE and dbus_req drops immediately.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt increments every cycle pc_hold=1.
  - flush_cnt increments every cycle IF_ID_flush=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- State encodings go in defines.v: `CTRL_IDLE, `CTRL_MEM_REQ, `CTRL_MEM_WAIT, `CTRL_DIV_BUSY, `CtrlStateBus.
- Existing `RegBus, `RegAddrBus, `ZeroWord and `Disable are reused.
- One sub-module, hazard_detect: the combinational load-use comparator, reused by the forwarding unit.

Test Plan:
- Load at EX writing x5 with ID rs1=x5, rs1_ren=1 -> pc_hold, IF_ID_hold and ID_EX_flush asserted for exactly 1 cycle. With rd=x0 -> no stall.
- EX_jump=1, target 0x0000_0100 -> jump_o=1, jump_addr_o=0x100, IF_ID_flush and ID_EX_flush asserted for 1 cycle. Load-use asserted in the same cycle -> no hold.
- Store with gnt delayed 3 cycles -> dbus_req held high 4 cycles, stall asserted 3 cycles, MEM_WB_flush asserted 3 cycles, FSM returns to IDLE. Zero-delay gnt -> no stall.
- Load with gnt at cycle 0 and rvalid at cycle 2 -> MEM_WAIT occupied 2 cycles, release on the rvalid cycle.
- Divide and load in MEM simultaneously, memory done after 2 cycles, div_done 5 cycles later -> MEM_REQ/MEM_WAIT first, then DIV_BUSY. EX_MEM_flush asserted during DIV_BUSY only. With PIPE_PERF_CNT_EN, stall_cnt equals the total hold cycles.
- rstn deasserted while in MEM_WAIT -> immediate IDLE, dbus_req=0, all holds 0.
